// File: rtl/soc_top.sv
// soc_top: board-level top for the 50 MHz bring-up image.
//   - led[0] heartbeat, led[1] RX byte toggle, led[2] TX busy, led[3] sticky RX error
//   - 8N1 UART: sends "READY\r\n" once after reset, then echoes received bytes
//     through a 1-entry holding register
//   - DDR3 pins parked: control outputs constant, data/strobe lines high-Z
// Ports:
//   clk50mhz      system clock, all logic on its rising edge
//   sys_rst       asynchronous active-high reset
//   led[3:0]      status LEDs, active-high
//   uart_rxd_out  UART TX from the FPGA, idles high
//   uart_txd_in   UART RX into the FPGA, asynchronous to clk50mhz
//   ddr3_*        parked DDR3 interface
module soc_top #(
   parameter int CLK_FREQ = 50000000,
   parameter int BAUD     = 115200,
   parameter int HB_DIV   = CLK_FREQ / 2
) (
   input  logic        clk50mhz,
   input  logic        sys_rst,
   output logic [3:0]  led,
   output logic        uart_rxd_out,
   input  logic        uart_txd_in,
   output logic        ddr3_reset_n,
   output logic        ddr3_cke,
   output logic        ddr3_ck_p,
   output logic        ddr3_ck_n,
   output logic        ddr3_cs_n,
   output logic        ddr3_ras_n,
   output logic        ddr3_cas_n,
   output logic        ddr3_we_n,
   output logic [2:0]  ddr3_ba,
   output logic [13:0] ddr3_addr,
   output logic        ddr3_odt,
   output logic [1:0]  ddr3_dm,
   inout  wire  [1:0]  ddr3_dqs_p,
   inout  wire  [1:0]  ddr3_dqs_n,
   inout  wire  [15:0] ddr3_dq
);

   localparam int BAUD_DIV = CLK_FREQ / BAUD;
   localparam int CW       = $clog2(BAUD_DIV + 1);
   localparam int HW       = $clog2(HB_DIV + 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);
   localparam logic [HW-1:0] HB_LAST   = HW'(HB_DIV - 1);

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;

   // DDR3 parked: memory held in reset with clock stopped, bus released
   assign ddr3_reset_n = 1'b0;
   assign ddr3_cke     = 1'b0;
   assign ddr3_ck_p    = 1'b0;
   assign ddr3_ck_n    = 1'b1;
   assign ddr3_cs_n    = 1'b1;
   assign ddr3_ras_n   = 1'b1;
   assign ddr3_cas_n   = 1'b1;
   assign ddr3_we_n    = 1'b1;
   assign ddr3_ba      = 3'b000;
   assign ddr3_addr    = 14'd0;
   assign ddr3_odt     = 1'b0;
   assign ddr3_dm      = 2'b00;
   assign ddr3_dqs_p   = 2'bzz;
   assign ddr3_dqs_n   = 2'bzz;
   assign ddr3_dq      = 16'bz;

   function automatic logic [7:0] banner_byte(input logic [2:0] i);
      case (i)
         3'd0:    banner_byte = 8'h52;
         3'd1:    banner_byte = 8'h45;
         3'd2:    banner_byte = 8'h41;
         3'd3:    banner_byte = 8'h44;
         3'd4:    banner_byte = 8'h59;
         3'd5:    banner_byte = 8'h0D;
         default: banner_byte = 8'h0A;
      endcase
   endfunction

   // state
   logic [HW-1:0] hb_cnt_q, hb_cnt_d;
   logic          hb_q, hb_d;
   logic          led1_q, led1_d;
   logic          err_q, err_d;

   tx_state_t     tx_state_q, tx_state_d;
   logic [CW-1:0] tx_cnt_q, tx_cnt_d;
   logic [2:0]    tx_bit_q, tx_bit_d;
   logic [7:0]    tx_sh_q, tx_sh_d;
   logic          tx_q, tx_d;
   logic [2:0]    ban_idx_q, ban_idx_d;
   logic          ban_done_q, ban_done_d;

   logic          rx_s1_q, rx_s2_q, rx_prev_q;
   rx_state_t     rx_state_q, rx_state_d;
   logic [CW-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]    rx_bit_q, rx_bit_d;
   logic [7:0]    rx_sh_q, rx_sh_d;

   logic [7:0]    hold_q, hold_d;
   logic          hold_full_q, hold_full_d;

   logic          tx_free, ban_ld, echo_ld, rx_valid, rx_ferr, rx_ovr;

   // TX can take a new byte from IDLE or at the last cycle of a stop bit,
   // which gives back-to-back frames with no idle gap.
   assign tx_free = (tx_state_q == TX_IDLE) ||
                    (tx_state_q == TX_STOP && tx_cnt_q == BIT_LAST);
   assign ban_ld  = !ban_done_q && (ban_idx_q != 3'd7) && tx_free;
   assign echo_ld = ban_done_q && hold_full_q && tx_free;

   // heartbeat
   always_comb begin
      hb_cnt_d = hb_cnt_q + 1'b1;
      hb_d     = hb_q;
      if (hb_cnt_q == HB_LAST) begin
         hb_cnt_d = '0;
         hb_d     = ~hb_q;
      end
   end

   // TX FSM and banner sequencer
   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_bit_d   = tx_bit_q;
      tx_sh_d    = tx_sh_q;
      ban_idx_d  = ban_idx_q;
      ban_done_d = ban_done_q;
      case (tx_state_q)
         TX_START: begin
            if (tx_cnt_q == BIT_LAST) begin
               tx_cnt_d   = '0;
               tx_bit_d   = 3'd0;
               tx_state_d = TX_DATA;
            end else begin
               tx_cnt_d = tx_cnt_q + 1'b1;
            end
         end
         TX_DATA: begin
            if (tx_cnt_q == BIT_LAST) begin
               tx_cnt_d = '0;
               tx_sh_d  = {1'b0, tx_sh_q[7:1]};
               if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
               else                  tx_bit_d   = tx_bit_q + 3'd1;
            end else begin
               tx_cnt_d = tx_cnt_q + 1'b1;
            end
         end
         TX_STOP: begin
            if (tx_cnt_q == BIT_LAST) begin
               tx_cnt_d   = '0;
               tx_state_d = TX_IDLE;
               // the stop bit of the last banner byte releases the echo path
               if (ban_idx_q == 3'd7) ban_done_d = 1'b1;
            end else begin
               tx_cnt_d = tx_cnt_q + 1'b1;
            end
         end
         default: ;
      endcase
      if (ban_ld || echo_ld) begin
         tx_state_d = TX_START;
         tx_cnt_d   = '0;
         tx_bit_d   = 3'd0;
         tx_sh_d    = ban_ld ? banner_byte(ban_idx_q) : hold_q;
         if (ban_ld) ban_idx_d = ban_idx_q + 3'd1;
      end
      // line level registered from next state so the pin is glitch-free
      case (tx_state_d)
         TX_START: tx_d = 1'b0;
         TX_DATA:  tx_d = tx_sh_d[0];
         default:  tx_d = 1'b1;
      endcase
   end

   // RX FSM; all sampling is relative to the detected falling edge
   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      rx_sh_d    = rx_sh_q;
      rx_valid   = 1'b0;
      rx_ferr    = 1'b0;
      case (rx_state_q)
         RX_IDLE: begin
            if (rx_prev_q && !rx_s2_q) begin
               rx_state_d = RX_START;
               rx_cnt_d   = '0;
            end
         end
         RX_START: begin
            if (rx_cnt_q == HALF_LAST) begin
               rx_cnt_d   = '0;
               rx_bit_d   = 3'd0;
               rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
            end else begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end
         RX_DATA: begin
            if (rx_cnt_q == BIT_LAST) begin
               rx_cnt_d = '0;
               rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
               if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
               else                  rx_bit_d   = rx_bit_q + 3'd1;
            end else begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end
         RX_STOP: begin
            if (rx_cnt_q == BIT_LAST) begin
               rx_cnt_d = '0;
               if (rx_s2_q) begin
                  rx_valid   = 1'b1;
                  rx_state_d = RX_IDLE;
               end else begin
                  rx_ferr    = 1'b1;
                  rx_state_d = RX_WAIT_HIGH;
               end
            end else begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end
         RX_WAIT_HIGH: begin
            // a held-low line yields a single error, then waits here
            if (rx_s2_q) rx_state_d = RX_IDLE;
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   // echo holding register; a slot freed by this cycle's load may be refilled
   always_comb begin
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      rx_ovr      = 1'b0;
      if (echo_ld) hold_full_d = 1'b0;
      if (rx_valid) begin
         if (!hold_full_q || echo_ld) begin
            hold_d      = rx_sh_q;
            hold_full_d = 1'b1;
         end else begin
            rx_ovr = 1'b1;
         end
      end
      led1_d = led1_q ^ rx_valid;
      err_d  = err_q | rx_ferr | rx_ovr;
   end

   always_ff @(posedge clk50mhz or posedge sys_rst) begin
      if (sys_rst) begin
         hb_cnt_q    <= '0;
         hb_q        <= 1'b0;
         led1_q      <= 1'b0;
         err_q       <= 1'b0;
         tx_state_q  <= TX_IDLE;
         tx_cnt_q    <= '0;
         tx_bit_q    <= 3'd0;
         tx_sh_q     <= 8'd0;
         tx_q        <= 1'b1;
         ban_idx_q   <= 3'd0;
         ban_done_q  <= 1'b0;
         rx_s1_q     <= 1'b1;
         rx_s2_q     <= 1'b1;
         rx_prev_q   <= 1'b1;
         rx_state_q  <= RX_IDLE;
         rx_cnt_q    <= '0;
         rx_bit_q    <= 3'd0;
         rx_sh_q     <= 8'd0;
         hold_q      <= 8'd0;
         hold_full_q <= 1'b0;
      end else begin
         hb_cnt_q    <= hb_cnt_d;
         hb_q        <= hb_d;
         led1_q      <= led1_d;
         err_q       <= err_d;
         tx_state_q  <= tx_state_d;
         tx_cnt_q    <= tx_cnt_d;
         tx_bit_q    <= tx_bit_d;
         tx_sh_q     <= tx_sh_d;
         tx_q        <= tx_d;
         ban_idx_q   <= ban_idx_d;
         ban_done_q  <= ban_done_d;
         rx_s1_q     <= uart_txd_in;
         rx_s2_q     <= rx_s1_q;
         rx_prev_q   <= rx_s2_q;
         rx_state_q  <= rx_state_d;
         rx_cnt_q    <= rx_cnt_d;
         rx_bit_q    <= rx_bit_d;
         rx_sh_q     <= rx_sh_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
      end
   end

   assign uart_rxd_out = tx_q;
   assign led          = {err_q, (tx_state_q != TX_IDLE), led1_q, hb_q};

endmodule

// File: tb/tb_soc_top.sv
module tb_soc_top;
   localparam int CLK_FREQ = 1600000;
   localparam int BAUD     = 100000;
   localparam int DIV      = CLK_FREQ / BAUD;   // 16 cycles per bit
   localparam int HB       = 100;

   logic        clk50mhz = 1'b0;
   logic        sys_rst;
   logic        uart_txd_in;
   logic [3:0]  led;
   logic        uart_rxd_out;
   logic        ddr3_reset_n, ddr3_cke, ddr3_ck_p, ddr3_ck_n;
   logic        ddr3_cs_n, ddr3_ras_n, ddr3_cas_n, ddr3_we_n;
   logic [2:0]  ddr3_ba;
   logic [13:0] ddr3_addr;
   logic        ddr3_odt;
   logic [1:0]  ddr3_dm;
   wire  [1:0]  ddr3_dqs_p, ddr3_dqs_n;
   wire  [15:0] ddr3_dq;
   logic [15:0] dq_pat = 16'h0;
   logic [3:0]  dqs_pat = 4'h0;

   // the bench owns the DDR3 data lines; the DUT must never fight it
   assign ddr3_dq    = dq_pat;
   assign ddr3_dqs_p = dqs_pat[1:0];
   assign ddr3_dqs_n = dqs_pat[3:2];

   always #10 clk50mhz = ~clk50mhz;

   soc_top #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .HB_DIV(HB)) dut (
      .clk50mhz(clk50mhz), .sys_rst(sys_rst), .led(led),
      .uart_rxd_out(uart_rxd_out), .uart_txd_in(uart_txd_in),
      .ddr3_reset_n(ddr3_reset_n), .ddr3_cke(ddr3_cke),
      .ddr3_ck_p(ddr3_ck_p), .ddr3_ck_n(ddr3_ck_n),
      .ddr3_cs_n(ddr3_cs_n), .ddr3_ras_n(ddr3_ras_n),
      .ddr3_cas_n(ddr3_cas_n), .ddr3_we_n(ddr3_we_n),
      .ddr3_ba(ddr3_ba), .ddr3_addr(ddr3_addr), .ddr3_odt(ddr3_odt),
      .ddr3_dm(ddr3_dm), .ddr3_dqs_p(ddr3_dqs_p), .ddr3_dqs_n(ddr3_dqs_n),
      .ddr3_dq(ddr3_dq)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int rel_cyc = 0;
   int frames_since;
   logic [7:0] exp_q[$];

   // reference model state: frames accepted, echo slot during banner, error flag
   int   valid_cnt;
   logic held;
   logic exp_err;

   always @(posedge clk50mhz) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Behavioural echo model: after the banner every byte comes back; during
   // the banner only the first byte fits the single slot, the rest are lost
   // and flag an error.
   task automatic model_rx(input logic [7:0] b, input logic during_banner);
      valid_cnt++;
      if (!during_banner) exp_q.push_back(b);
      else if (!held) begin
         held = 1'b1;
         exp_q.push_back(b);
      end else exp_err = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      logic [9:0] fr;
      fr = {1'b1, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         @(negedge clk50mhz);
         uart_txd_in = fr[i];
         repeat (DIV - 1) @(negedge clk50mhz);
      end
   endtask

   task automatic do_reset(input logic rx_level);
      logic [7:0] ban [7];
      ban = '{8'h52, 8'h45, 8'h41, 8'h44, 8'h59, 8'h0D, 8'h0A};
      @(negedge clk50mhz);
      sys_rst     = 1'b1;
      uart_txd_in = rx_level;
      #500;
      chk("reset led", 32'(led), 32'h0);
      chk("reset tx idle", 32'(uart_rxd_out), 32'h1);
      exp_q.delete();
      for (int i = 0; i < 7; i++) exp_q.push_back(ban[i]);
      valid_cnt = 0;
      held      = 1'b0;
      exp_err   = 1'b0;
      @(negedge clk50mhz);
      rel_cyc = cyc;
      sys_rst = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clk50mhz);
         n++;
      end
      if (n >= budget) begin
         checks++;
         errors++;
         $display("FAIL drain timeout: %0d frames still outstanding, required 0", exp_q.size());
      end
      repeat (2 * DIV) @(negedge clk50mhz);
   endtask

   // monitor: decodes uart_rxd_out on its own and scores against exp_q
   initial begin : monitor
      logic [7:0] b;
      logic [7:0] e;
      int last_start;
      frames_since = 0;
      last_start   = 0;
      forever begin
         @(negedge clk50mhz);
         if (sys_rst) frames_since = 0;
         else if (uart_rxd_out == 1'b0) begin
            if (frames_since == 0)
               chk("first start latency", 32'(cyc - rel_cyc), 32'd1);
            else if (frames_since < 7)
               chk("banner frame spacing", 32'(cyc - last_start), 32'(10 * DIV));
            last_start = cyc;
            frames_since++;
            repeat (DIV / 2) @(negedge clk50mhz);
            chk("start bit", 32'(uart_rxd_out), 32'h0);
            chk("led2 busy in frame", 32'(led[2]), 32'h1);
            for (int i = 0; i < 8; i++) begin
               repeat (DIV) @(negedge clk50mhz);
               b[i] = uart_rxd_out;
            end
            repeat (DIV) @(negedge clk50mhz);
            chk("stop bit", 32'(uart_rxd_out), 32'h1);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected frame: got %02h, required none", b);
            end else begin
               e = exp_q.pop_front();
               chk("tx byte", 32'(b), 32'(e));
            end
         end
      end
   end

   // DDR3 parking, sampled throughout including reset
   initial begin : ddr_mon
      forever begin
         repeat (37) @(negedge clk50mhz);
         chk("ddr3 ctrl", 32'({ddr3_reset_n, ddr3_cke, ddr3_ck_p, ddr3_ck_n, ddr3_cs_n,
                               ddr3_ras_n, ddr3_cas_n, ddr3_we_n, ddr3_ba, ddr3_addr,
                               ddr3_odt, ddr3_dm}),
             32'({1'b0, 1'b0, 1'b0, 1'b1, 4'hF, 3'd0, 14'd0, 1'b0, 2'd0}));
         dq_pat  = 16'($urandom);
         dqs_pat = 4'($urandom);
         #1;
         chk("ddr3 dq released", 32'(ddr3_dq), 32'(dq_pat));
         chk("ddr3 dqs released", 32'({ddr3_dqs_n, ddr3_dqs_p}), 32'(dqs_pat));
      end
   end

   initial begin : watchdog
      #5ms;
      $display("FAIL watchdog: simulation did not complete, %0d checks so far", checks);
      $fatal(1, "watchdog");
   end

   initial begin : stim
      logic [7:0] b;
      logic       p;
      int         last, n;
      sys_rst     = 1'b1;
      uart_txd_in = 1'b1;

      // banner after reset, heartbeat period
      do_reset(1'b1);
      p    = led[0];
      last = rel_cyc;
      for (int k = 0; k < 3; k++) begin
         n = 0;
         while (led[0] == p && n < 3 * HB) begin
            @(negedge clk50mhz);
            n++;
         end
         chk("heartbeat period", 32'(cyc - last), 32'(HB));
         last = cyc;
         p    = led[0];
      end
      wait_drain(100 * DIV);
      chk("led2 idle after banner", 32'(led[2]), 32'h0);
      chk("led3 clear after banner", 32'(led[3]), 32'h0);
      chk("led1 no rx", 32'(led[1]), 32'h0);

      // single echo
      model_rx(8'hA5, 1'b0);
      send_byte(8'hA5);
      wait_drain(40 * DIV);
      chk("led1 after A5", 32'(led[1]), 32'(valid_cnt & 1));
      chk("led3 after A5", 32'(led[3]), 32'(exp_err));

      // three back-to-back
      for (int i = 0; i < 3; i++) begin
         b = 8'($urandom);
         model_rx(b, 1'b0);
         send_byte(b);
      end
      wait_drain(60 * DIV);
      chk("led1 after burst", 32'(led[1]), 32'(valid_cnt & 1));
      chk("led3 no overrun", 32'(led[3]), 32'(exp_err));

      // random bytes with random spacing
      for (int i = 0; i < 6; i++) begin
         b = 8'($urandom);
         model_rx(b, 1'b0);
         send_byte(b);
         repeat ($urandom_range(0, 3 * DIV)) @(negedge clk50mhz);
      end
      wait_drain(60 * DIV);
      chk("led1 after random", 32'(led[1]), 32'(valid_cnt & 1));
      chk("led3 after random", 32'(led[3]), 32'(exp_err));

      // bytes arriving during the banner
      do_reset(1'b1);
      repeat (5 * DIV) @(negedge clk50mhz);
      for (int i = 0; i < 3; i++) begin
         b = 8'($urandom);
         model_rx(b, 1'b1);
         send_byte(b);
      end
      wait_drain(120 * DIV);
      chk("led3 overrun", 32'(led[3]), 32'(exp_err));
      chk("led1 during banner", 32'(led[1]), 32'(valid_cnt & 1));

      // line held low through reset: one framing error, no bytes
      do_reset(1'b0);
      repeat (10 * DIV + 4) @(negedge clk50mhz);
      chk("led3 break error", 32'(led[3]), 32'h1);
      wait_drain(100 * DIV);
      chk("led3 sticky", 32'(led[3]), 32'h1);
      chk("led1 no byte on break", 32'(led[1]), 32'h0);
      uart_txd_in = 1'b1;
      repeat (4 * DIV) @(negedge clk50mhz);
      chk("led3 sticky after release", 32'(led[3]), 32'h1);
      chk("no echo after break", 32'(exp_q.size()), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/soc_top.md
Name: soc_top

Overview:
- FPGA board-level top for the 50 MHz board bring-up image.
- Provides a 4-LED status display and a 115200-baud UART that sends a fixed boot banner after reset, then echoes received bytes.
- Parks the DDR3 interface in a safe, inactive state; no memory controller is instantiated.
- Self-contained; no sub-IP beyond plain RTL.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 115200, UART bit rate; BAUD_DIV = CLK_FREQ/BAUD (integer division), 434 at defaults.
- HB_DIV, CLK_FREQ/2, heartbeat half-period in cycles (benches may override, e.g. 100).

Ports:
- clk50mhz  in  1  system clock; all logic on its rising edge.
- sys_rst  in  1  reset, asynchronous, active-high.
- led  out  4  status LEDs, active-high.
- uart_rxd_out  out  1  UART TX from the FPGA (named from the USB bridge's view); idles high.
- uart_txd_in  in  1  UART RX into the FPGA; asynchronous to clk50mhz.
- ddr3_reset_n  out  1  DDR3 reset, held 0.
- ddr3_cke  out  1  held 0.
- ddr3_ck_p  out  1  held 0.
- ddr3_ck_n  out  1  held 1.
- ddr3_cs_n, ddr3_ras_n, ddr3_cas_n, ddr3_we_n  out  1 each  held 1.
- ddr3_ba  out  3  held 0.
- ddr3_addr  out  14  held 0.
- ddr3_odt  out  1  held 0.
- ddr3_dm  out  2  held 0.
- ddr3_dqs_p, ddr3_dqs_n  inout  2  always high-Z.
- ddr3_dq  inout  16  always high-Z.

Behaviour:
- All flops use an asynchronous active-high reset on sys_rst. DDR3 outputs are constants, independent of reset.
- Reset values: led=4'b0000, uart_rxd_out=1, every counter and FSM at zero/IDLE.
- led[0] heartbeat: toggles every HB_DIV cycles.
- led[1]: toggles once per correctly received RX byte.
- led[2]: 1 while the TX shifter is busy.
- led[3]: sticky error. Set on an RX framing error or an RX overrun; cleared only by reset.
- UART frame: 8N1, LSB first, each bit exactly BAUD_DIV cycles.
- TX FSM states IDLE -> START -> DATA(8) -> STOP -> IDLE.
  - A load takes 1 cycle from IDLE; the start bit appears on the next clock.
  - The frame is 10*BAUD_DIV cycles long.
  - Back-to-back frames are permitted with no extra idle.
- Banner: 7 bytes 0x52 0x45 0x41 0x44 0x59 0x0D 0x0A ("READY\r\n").
  - Sent once, starting on the first clock after reset deasserts.
  - Sent back-to-back.
  - Echo is inhibited until the last banner byte's stop bit completes.
- RX path:
  - 2-flop synchronizer.
  - RX states IDLE -> START -> DATA -> STOP -> (WAIT_HIGH on error) -> IDLE.
  - IDLE: a start is detected on a high-to-low transition of the synchronized line.
  - START: re-sampled at BAUD_DIV/2; if high, treat as a glitch and return to IDLE.
  - DATA: each data bit is sampled at mid-bit.
  - STOP: stop bit sampled at mid-bit.
  - Stop=1: the byte is valid.
  - Stop=0: framing error. Discard the byte, set led[3], go to WAIT_HIGH.
  - WAIT_HIGH: stays there until the synchronized line is high, so a held-low/break line produces exactly one error and no bytes.
- Echo buffer: 1-entry holding register.
  - A valid byte is written to the holding register, then handed to TX when TX is IDLE and the banner is done.
  - A valid byte arriving while the holding register is full is dropped and sets led[3] (overrun).
  - Bytes received during the banner are held (1 entry) and echoed after it.
- Reset mid-frame: uart_rxd_out returns to 1 immediately, and the banner restarts from byte 0 after release.

Test Plan:
- Reset high 500 ns, then release; uart_txd_in=1 -> 7 frames decode as 52 45 41 44 59 0D 0A, each bit 434 clocks; led[2]=1 during the banner, 0 after.
- uart_txd_in held 0 from reset -> after release led[3]=1 within 10 bit-times and stays 1; no echo bytes, only the banner; led[1] stays 0.
- After the banner, send 0xA5 at 115200 -> 0xA5 echoed on uart_rxd_out; led[1] toggles to 1; led[3]=0.
- Send 3 bytes back-to-back after the banner -> all 3 echoed in order, no overrun.
- Send 3 bytes during the banner -> first held and echoed after 0x0A; the later ones are dropped, and led[3]=1.
- With HB_DIV=100 -> led[0] toggles every 100 clocks. Check all DDR3 outputs hold their constants and dq/dqs are Z throughout, including during reset.
